// File: rtl/bcd_seg_pkg.sv
// Shared constants for the BCD 7-segment scanner: segment patterns,
// digit count and scan FSM state encoding.
package bcd_seg_pkg;

    // Segment patterns, bit 0 = a .. bit 6 = g, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Four magnitude digits plus the sign position
    localparam int DIG_NUM = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    function automatic logic nib_bad(input logic [3:0] n);
        return n > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Bundle between the BCD producer and the display scanner.
interface bcd_seg_scan_if;
    logic [16:0] bcd;
    logic        bcd_vld;
    logic [6:0]  seg;
    logic [4:0]  dig_en;
    logic        disp_val;
    logic        bcd_err;

    modport master (
        output bcd, bcd_vld,
        input  seg, dig_en, disp_val, bcd_err
    );

    modport slave (
        input  bcd, bcd_vld,
        output seg, dig_en, disp_val, bcd_err
    );
endinterface

// File: rtl/seg7_dec.sv
// Nibble to 7-segment pattern; any non-decimal nibble shows 'E'.
module seg7_dec
    import bcd_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure lookup, no blanking decisions here
    always_comb begin
        seg = SEG_E;
        case (nib)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed 5-position 7-segment scanner for signed BCD values.
//
// state    | meaning
// ST_IDLE  | nothing captured since reset, display dark
// ST_BLANK | start of a digit slot, all enables low (anti-ghosting)
// ST_DRIVE | remainder of the slot, current digit enabled
//
// The captured value is copied to a shadow only at frame start, so a
// frame in progress always shows one consistent value.
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic           clk,
    input  logic           rstn,
    bcd_seg_scan_if.slave  bus
);

    localparam int              CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [2:0]       DIG_LAST  = 3'(DIG_NUM - 1);

    scan_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        dig_q, dig_d;
    logic [16:0]       hold_q, hold_d;
    logic [16:0]       shadow_q, shadow_d;
    logic              disp_val_q, disp_val_d;
    logic              bcd_err_q, bcd_err_d;
    logic [6:0]        seg_q, seg_d;
    logic [4:0]        dig_en_q, dig_en_d;

    logic [3:0]        nib_sel;
    logic              blank_sel;
    logic [6:0]        dec_seg;
    logic              zero3, zero2, zero1, mag_zero;

    // Capture path: last bcd_vld wins, error flag tracks the latest capture
    always_comb begin
        hold_d     = hold_q;
        disp_val_d = disp_val_q;
        bcd_err_d  = bcd_err_q;
        if (bus.bcd_vld) begin
            hold_d     = bus.bcd;
            disp_val_d = 1'b1;
            bcd_err_d  = nib_bad(bus.bcd[15:12]) | nib_bad(bus.bcd[11:8]) |
                         nib_bad(bus.bcd[7:4])   | nib_bad(bus.bcd[3:0]);
        end
    end

    // Scan sequencing: slot counter, digit index, frame-start shadow load
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dig_d    = dig_q;
        shadow_d = shadow_q;
        if (state_q == ST_IDLE) begin
            if (disp_val_q) begin
                cnt_d    = '0;
                dig_d    = 3'd0;
                shadow_d = hold_q;
                state_d  = (cnt_d < BLANK_LIM) ? ST_BLANK : ST_DRIVE;
            end
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (dig_q == DIG_LAST) begin
                    dig_d    = 3'd0;
                    shadow_d = hold_q;
                end else begin
                    dig_d = dig_q + 3'd1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = (cnt_d < BLANK_LIM) ? ST_BLANK : ST_DRIVE;
        end
    end

    assign zero3    = (shadow_d[15:12] == 4'd0);
    assign zero2    = (shadow_d[11:8]  == 4'd0);
    assign zero1    = (shadow_d[7:4]   == 4'd0);
    assign mag_zero = zero3 & zero2 & zero1 & (shadow_d[3:0] == 4'd0);

    // Select the nibble for the upcoming digit and its leading-zero status
    always_comb begin
        nib_sel   = 4'd0;
        blank_sel = 1'b0;
        case (dig_d)
            3'd0: nib_sel = shadow_d[3:0];
            3'd1: begin
                nib_sel   = shadow_d[7:4];
                blank_sel = zero3 & zero2 & zero1;
            end
            3'd2: begin
                nib_sel   = shadow_d[11:8];
                blank_sel = zero3 & zero2;
            end
            3'd3: begin
                nib_sel   = shadow_d[15:12];
                blank_sel = zero3;
            end
            default: ;
        endcase
    end

    seg7_dec u_dec (
        .nib (nib_sel),
        .seg (dec_seg)
    );

    // Output pattern for the next cycle; dark outside DRIVE
    always_comb begin
        seg_d    = SEG_BLANK;
        dig_en_d = 5'b00000;
        if (state_d == ST_DRIVE) begin
            dig_en_d = 5'b00001 << dig_d;
            if (dig_d == DIG_LAST) begin
                seg_d = (shadow_d[16] && !mag_zero) ? SEG_MINUS : SEG_BLANK;
            end else begin
                seg_d = blank_sel ? SEG_BLANK : dec_seg;
            end
        end
    end

    // All state and outputs registered, cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dig_q      <= 3'd0;
            hold_q     <= '0;
            shadow_q   <= '0;
            disp_val_q <= 1'b0;
            bcd_err_q  <= 1'b0;
            seg_q      <= SEG_BLANK;
            dig_en_q   <= 5'b00000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dig_q      <= dig_d;
            hold_q     <= hold_d;
            shadow_q   <= shadow_d;
            disp_val_q <= disp_val_d;
            bcd_err_q  <= bcd_err_d;
            seg_q      <= seg_d;
            dig_en_q   <= dig_en_d;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.dig_en   = dig_en_q;
    assign bus.disp_val = disp_val_q;
    assign bus.bcd_err  = bcd_err_q;

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
Downstream consumer of the bin2bcd stage. Captures each signed BCD result on bcd_vld and drives a 5-position multiplexed common-enable 7-segment display: four magnitude digits plus one sign position. Time-multiplexes the digits with a programmable slot length and inter-digit blanking (anti-ghosting), suppresses leading zeros, and updates the shown value only at frame boundaries.

Parameters:
SCAN_DIV, 1000, clk cycles per digit slot (blank + drive); must be > BLANK_CYC and >= 2
BLANK_CYC, 16, cycles at start of each slot with all dig_en low; 0 = no blanking

Ports:
clk  input  1  system clock
rstn  input  1  reset; asynchronous, active-low
bcd  input  17  [16] sign (1 = negative), [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones
bcd_vld  input  1  one-cycle qualifier for bcd, no backpressure
seg  output  7  segments, active high, [0]=a .. [6]=g
dig_en  output  5  one-hot digit enable, active high; [0]=ones .. [3]=thousands, [4]=sign
disp_val  output  1  a value has been captured since reset
bcd_err  output  1  last captured value contained a nibble > 9

Behaviour:
- Reset (async, rstn low): seg=0, dig_en=0, disp_val=0, bcd_err=0, hold/shadow regs=0, FSM=IDLE, counters=0. Effective immediately, including mid-frame.
- Capture: bcd_vld sampled at posedge T -> hold<=bcd, disp_val<=1, bcd_err<=(any nibble >9). Back-to-back bcd_vld: last wins. Capture never disturbs the frame in progress.
- FSM: IDLE -> BLANK -> DRIVE -> BLANK ... IDLE left only when disp_val=1 and never re-entered except by reset.
- Frame start = entry to BLANK of digit 0: shadow<=hold, slot counter=0, digit index=0.
- Slot: counter 0..SCAN_DIV-1. Counter < BLANK_CYC: BLANK, dig_en=0, seg=0. Otherwise DRIVE: dig_en=one-hot(digit), seg=decode(digit). At counter=SCAN_DIV-1: counter->0, digit increments 0..4, wraps 4->0 (new frame, shadow reload).
- Timing: first capture at edge T -> leave IDLE at edge T+1 (frame start); dig_en[0] first asserted at edge T+1+BLANK_CYC. All outputs registered.
- Encoding: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F, '-'=0x40, 'E'=0x79, blank=0x00.
- Nibble > 9 displays 'E' in that position and is never blanked.
- Leading-zero blanking: thousands blank if 0; hundreds blank if thousands and hundreds both 0; tens blank if thousands, hundreds, tens all 0; ones always shown. A blanked digit still gets its dig_en slot with seg=0x00 (constant scan timing).
- Sign digit: '-' if sign=1 and magnitude !=0; blank otherwise (-0 shows "0").
- bcd_err: sticky per capture; cleared by the next capture with all nibbles <=9.
- Counter width = clog2(SCAN_DIV); no other arithmetic.

Decomposition:
- Package bcd_seg_pkg: segment constants (SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_BLANK), DIG_NUM=5, FSM state encoding.
- Sub-module seg7_dec: combinational 4-bit nibble -> 7-bit pattern ('E' for >9). Blanking and sign logic stay in bcd_seg_scan.

Test Plan:
(All with SCAN_DIV=8, BLANK_CYC=2.)
- Reset, no bcd_vld for 100 cycles -> dig_en=0, seg=0, disp_val=0 throughout.
- bcd=0x00123 -> per frame: dig_en 00001 seg 0x4F; 00010 0x5B; 00100 0x06; 01000 0x00; 10000 0x00. Each slot has 2 blank cycles then 6 drive cycles. First dig_en at T+3.
- bcd=0x11023 (-1023) -> 0x4F, 0x5B, 0x3F (inner zero shown), 0x06, sign 0x40. bcd=0x10000 (-0) -> ones 0x3F, all others 0x00.
- Frame showing 0x00123; bcd_vld with 0x00045 during digit 2 -> rest of frame unchanged. Next frame shows 0x6D, 0x66, blank, blank, blank. Two consecutive vld pulses (0x00001 then 0x00002) -> next frame shows 2.
- bcd=0x000A5 -> tens 0x79, ones 0x6D, bcd_err=1. Then 0x00005 -> bcd_err=0, tens blank.
- rstn low mid-DRIVE (async, between edges) -> seg/dig_en/disp_val 0 immediately. After release, display stays blank until next bcd_vld.
